// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage -- decode/execute pipeline register with load-use interlock.
//
// Holds one instruction between decode and execute. It advances when execute
// accepts the held instruction or the slot is empty. When the held
// instruction is a load whose destination feeds a source operand of the
// decoding instruction, one bubble is inserted and decode is stalled for a
// single cycle. A flush kills the decode slot only.
//
// Configuration:
//   ID_EX_FLOAT_HAZARD_EN  when defined, float-load-use hazards (flw followed
//                          by a float consumer) are also interlocked; f0 is
//                          not exempt. Undefined: integer hazards only.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid / id_ready     decode handshake (id_ready is combinational)
//   id_signals[18:0]        control bundle (4 RegWrite, 5 MemRead,
//                           15 float reg write, 16/17 dataA/dataB float sel)
//   id_pc, id_dataA, id_dataB, id_imm   32-bit decode payload
//   id_rs1, id_rs2, id_rd   register indices
//   flush                   redirect; kills the decode slot
//   ex_ready / ex_valid     execute handshake
//   ex_*                    registered copies of the id_* payload
//   bubble_cnt[7:0]         saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [18:0] id_signals,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_dataA,
  input  logic [31:0] id_dataB,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [18:0] ex_signals,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_dataA,
  output logic [31:0] ex_dataB,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [4:0]  ex_rd,
  output logic [7:0]  bubble_cnt
);

  localparam int unsigned SIG_REG_WRITE   = 4;
  localparam int unsigned SIG_MEM_READ    = 5;
  localparam int unsigned SIG_FREG_WRITE  = 15;
  localparam int unsigned SIG_A_FLOAT_SEL = 16;
  localparam int unsigned SIG_B_FLOAT_SEL = 17;

  logic advance;
  logic rs1_match;
  logic rs2_match;
  logic hazard_int;
  logic hazard_flt;
  logic hazard;

  // The register may take a new entry when execute drains it or it is empty.
  assign advance   = ex_ready | ~ex_valid;

  assign rs1_match = (ex_rd == id_rs1);
  assign rs2_match = (ex_rd == id_rs2);

  // Integer load-use: x0 never carries a dependency. The float-select bits
  // say the operand comes from the float file, so an integer load cannot
  // feed it.
  assign hazard_int = ex_valid & ex_signals[SIG_MEM_READ] & ex_signals[SIG_REG_WRITE]
                    & (ex_rd != 5'd0)
                    & ((rs1_match & ~id_signals[SIG_A_FLOAT_SEL])
                     | (rs2_match & ~id_signals[SIG_B_FLOAT_SEL]));

`ifdef ID_EX_FLOAT_HAZARD_EN
  // Float load-use: f0 is an ordinary register, so no zero exemption.
  assign hazard_flt = ex_valid & ex_signals[SIG_MEM_READ] & ex_signals[SIG_FREG_WRITE]
                    & ((rs1_match & id_signals[SIG_A_FLOAT_SEL])
                     | (rs2_match & id_signals[SIG_B_FLOAT_SEL]));
`else
  // Float-load scheduling is left to software.
  assign hazard_flt = 1'b0;
`endif

  // Only a live, unflushed decode slot can stall.
  assign hazard   = id_valid & ~flush & (hazard_int | hazard_flt);

  // Flush always lets decode go (its instruction is discarded anyway).
  assign id_ready = advance & (flush | ~hazard);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; all state is reset asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_signals <= '0;
      ex_pc      <= '0;
      ex_dataA   <= '0;
      ex_dataB   <= '0;
      ex_imm     <= '0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      bubble_cnt <= '0;
    end else if (advance) begin
      if (flush || hazard || !id_valid) begin
        // Bubble: payload fields are left as they were.
        ex_valid   <= 1'b0;
        ex_signals <= '0;
        if (hazard && (bubble_cnt != 8'hFF)) begin
          bubble_cnt <= bubble_cnt + 8'd1;
        end
      end else begin
        ex_valid   <= 1'b1;
        ex_signals <= id_signals;
        ex_pc      <= id_pc;
        ex_dataA   <= id_dataA;
        ex_dataB   <= id_dataB;
        ex_imm     <= id_imm;
        ex_rs1     <= id_rs1;
        ex_rs2     <= id_rs2;
        ex_rd      <= id_rd;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage -- self-checking bench for id_ex_stage.
//
// Directed scenarios (load-use, x0 load, backpressure, flush during hazard,
// float load-use, reset mid-operation and mid-stall, counter saturation)
// followed by randomized traffic. Expected values come from a transaction
// level model of the register contents kept in this file. Honors
// ID_EX_FLOAT_HAZARD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [18:0] id_signals;
  logic [31:0] id_pc, id_dataA, id_dataB, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [18:0] ex_signals;
  logic [31:0] ex_pc, ex_dataA, ex_dataB, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  bubble_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready), .id_signals(id_signals),
    .id_pc(id_pc), .id_dataA(id_dataA), .id_dataB(id_dataB), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_signals(ex_signals), .ex_pc(ex_pc), .ex_dataA(ex_dataA),
    .ex_dataB(ex_dataB), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the pipeline register should hold.
  typedef struct {
    bit          valid;
    bit [18:0]   sig;
    bit [31:0]   pc, a, b, imm;
    bit [4:0]    rs1, rs2, rd;
    int unsigned bubbles;
  } slot_t;

  slot_t m;

  int n_tests = 0;
  int n_fail  = 0;

  // Control bundles used by the directed scenarios.
  localparam logic [18:0] SIG_LW   = 19'h00030; // MemRead + RegWrite
  localparam logic [18:0] SIG_ADD  = 19'h00010; // RegWrite
  localparam logic [18:0] SIG_FLW  = 19'h08020; // MemRead + float reg write
  localparam logic [18:0] SIG_FADD = 19'h38000; // float write, A/B float sel

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m = '{valid: 1'b0, sig: '0, pc: '0, a: '0, b: '0, imm: '0,
          rs1: '0, rs2: '0, rd: '0, bubbles: 0};
  endfunction

  // Does the decode instruction read a register the held load writes?
  function automatic bit exp_hazard();
    bit h;
    h = 1'b0;
    if (id_valid && !flush && m.valid && m.sig[5]) begin
      if (m.sig[4] && m.rd != 0 &&
          ((m.rd == id_rs1 && !id_signals[16]) || (m.rd == id_rs2 && !id_signals[17])))
        h = 1'b1;
`ifdef ID_EX_FLOAT_HAZARD_EN
      if (m.sig[15] &&
          ((m.rd == id_rs1 && id_signals[16]) || (m.rd == id_rs2 && id_signals[17])))
        h = 1'b1;
`endif
    end
    return h;
  endfunction

  task automatic check_outputs();
    check("ex_valid",   ex_valid,   m.valid);
    check("ex_signals", ex_signals, m.sig);
    check("ex_pc",      ex_pc,      m.pc);
    check("ex_dataA",   ex_dataA,   m.a);
    check("ex_dataB",   ex_dataB,   m.b);
    check("ex_imm",     ex_imm,     m.imm);
    check("ex_rs1",     ex_rs1,     m.rs1);
    check("ex_rs2",     ex_rs2,     m.rs2);
    check("ex_rd",      ex_rd,      m.rd);
    check("bubble_cnt", bubble_cnt, m.bubbles);
  endtask

  // One clock: entered at a negedge with inputs already driven, leaves at
  // the following negedge.
  task automatic cycle();
    bit adv, hz;
    #1;
    adv = !m.valid || ex_ready;
    hz  = exp_hazard();
    check("id_ready", id_ready, adv && (flush || !hz));
    @(posedge clk);
    if (adv) begin
      if (flush || hz || !id_valid) begin
        m.valid = 1'b0;
        m.sig   = '0;
        if (hz && m.bubbles < 255) m.bubbles++;
      end else begin
        m.valid = 1'b1;
        m.sig = id_signals; m.pc = id_pc; m.a = id_dataA; m.b = id_dataB;
        m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
      end
    end
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input logic [18:0] sig, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
    id_valid   = v;
    id_signals = sig;
    id_pc      = $urandom;
    id_dataA   = $urandom;
    id_dataB   = $urandom;
    id_imm     = $urandom;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_rd      = rd;
  endtask

  task automatic rand_inputs();
    set_id(($urandom % 4) != 0, 19'($urandom), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    flush    = ($urandom % 8) == 0;
    ex_ready = ($urandom % 4) != 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_ex_valid",   ex_valid,   0);
    check("rst_ex_signals", ex_signals, 0);
    check("rst_ex_pc",      ex_pc,      0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] held_pc;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    set_id(1'b0, '0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Load-use: lw x5 then add using x5.
    flush = 1'b0; ex_ready = 1'b1;
    set_id(1'b1, SIG_LW, 5'd1, 5'd2, 5'd5);
    cycle();
    set_id(1'b1, SIG_ADD, 5'd5, 5'd7, 5'd9);
    #1 check("lu_ready_low", id_ready, 0);
    cycle();
    check("lu_bubble_cnt", bubble_cnt, 1);
    check("lu_bubble_valid", ex_valid, 0);
    #1 check("lu_ready_back", id_ready, 1);
    cycle();
    check("lu_add_in_ex", ex_rs1, 5);
    check("lu_add_valid", ex_valid, 1);

    // Load into x0 with consumer reading x0: no stall.
    set_id(1'b1, SIG_LW, 5'd1, 5'd2, 5'd0);
    cycle();
    set_id(1'b1, SIG_ADD, 5'd3, 5'd0, 5'd4);
    #1 check("x0_ready", id_ready, 1);
    cycle();
    check("x0_cnt", bubble_cnt, 1);

    // Backpressure for three cycles, then release.
    held_pc = ex_pc;
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, SIG_ADD, 5'd1, 5'd2, 5'd3);
      #1 check("bp_ready", id_ready, 0);
      cycle();
      check("bp_pc_hold", ex_pc, held_pc);
    end
    ex_ready = 1'b1;
    cycle();
    check("bp_capture", ex_pc, id_pc);

    // Flush during a load-use hazard.
    set_id(1'b1, SIG_LW, 5'd1, 5'd2, 5'd6);
    cycle();
    set_id(1'b1, SIG_ADD, 5'd6, 5'd6, 5'd8);
    flush = 1'b1;
    #1 check("fl_ready", id_ready, 1);
    cycle();
    check("fl_cnt", bubble_cnt, 1);
    check("fl_bubble", ex_valid, 0);
    flush = 1'b0;

    // Flush while stalled by backpressure leaves the register alone.
    set_id(1'b1, SIG_ADD, 5'd1, 5'd2, 5'd3);
    cycle();
    held_pc = ex_pc;
    ex_ready = 1'b0; flush = 1'b1;
    cycle();
    check("fl_hold_pc", ex_pc, held_pc);
    check("fl_hold_valid", ex_valid, 1);
    ex_ready = 1'b1; flush = 1'b0;

    // Float load-use: flw f3 then fadd reading f3.
    set_id(1'b1, SIG_FLW, 5'd1, 5'd2, 5'd3);
    cycle();
    set_id(1'b1, SIG_FADD, 5'd3, 5'd4, 5'd5);
`ifdef ID_EX_FLOAT_HAZARD_EN
    #1 check("flt_ready", id_ready, 0);
    cycle();
    check("flt_cnt", bubble_cnt, 2);
`else
    #1 check("flt_ready", id_ready, 1);
    cycle();
    check("flt_cnt", bubble_cnt, 1);
`endif
    cycle();

    // Reset mid-stall with a valid instruction held.
    set_id(1'b1, SIG_ADD, 5'd1, 5'd2, 5'd3);
    cycle();
    ex_ready = 1'b0;
    cycle();
    check("pre_rst_valid", ex_valid, 1);
    do_reset();
    cycle(); // empty register captures despite ex_ready=0
    check("post_rst_capture", ex_valid, 1);
    ex_ready = 1'b1;

    // Drive the bubble counter into saturation.
    for (int i = 0; i < 260; i++) begin
      set_id(1'b1, SIG_LW, 5'd0, 5'd0, 5'd7);
      cycle();
      set_id(1'b1, SIG_ADD, 5'd1, 5'd7, 5'd2);
      cycle();
    end
    check("sat_cnt", bubble_cnt, 8'hFF);

    // Randomized traffic after a fresh reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: the stimulus above is bounded, this only guards against a hang.
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
